// File: rtl/mfsk_pkg.sv
// Shared definitions for the M-ary FSK modulator: FSM state codes and the
// saturating half-period computation used at symbol load.
package mfsk_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // base + sym*step, clamped to the tone counter range; zero means one cycle.
    function automatic logic [31:0] sat_half(input logic [31:0] base,
                                             input logic [31:0] step,
                                             input logic [31:0] sym,
                                             input int unsigned div_w);
        logic [63:0] sum;
        logic [63:0] lim;
        sum = {32'd0, base} + {32'd0, sym} * {32'd0, step};
        lim = (64'd1 << div_w) - 64'd1;
        if (sum > lim)
            sum = lim;
        if (sum == 64'd0)
            sum = 64'd1;
        return sum[31:0];
    endfunction

endpackage

// File: rtl/mfsk_tone_gen.sv
// Square-wave tone generator: half-period counter with phase toggle.
// Define MFSK_PHASE_CONT_EN to keep phase across symbol boundaries.
module mfsk_tone_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] half,
    output logic             phase
);

`ifdef MFSK_PHASE_CONT_EN
    localparam bit KEEP_PHASE = 1'b1;
`else
    localparam bit KEEP_PHASE = 1'b0;
`endif

    logic [DIV_W-1:0] half_q;
    logic [DIV_W-1:0] tone_cnt;
    logic [DIV_W-1:0] reload_val;

    // A load coinciding with a reload already uses the new symbol's period.
    assign reload_val = load ? half - DIV_W'(1) : half_q - DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q   <= '0;
            tone_cnt <= '0;
            phase    <= 1'b0;
        end else if (load && (!run || !KEEP_PHASE)) begin
            half_q   <= half;
            tone_cnt <= half - DIV_W'(1);
            phase    <= 1'b1;
        end else if (run) begin
            if (load)
                half_q <= half;
            if (tone_cnt == '0) begin
                tone_cnt <= reload_val;
                phase    <= ~phase;
            end else begin
                tone_cnt <= tone_cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator top: symbol handshake, hold register, FSM and baud timer.
// Optional MFSK_PHASE_CONT_EN selects phase-continuous tone switching.
module mfsk_modulator
    import mfsk_pkg::*;
#(
    parameter int SYM_BITS = 2,
    parameter int DIV_W    = 16,
    parameter int BAUD_W   = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                en,
    input  logic [DIV_W-1:0]    cfg_base,
    input  logic [DIV_W-1:0]    cfg_step,
    input  logic [BAUD_W-1:0]   cfg_baud,
    input  logic [SYM_BITS-1:0] sym_data,
    input  logic                sym_valid,
    output logic                sym_ready,
    output logic                fsk_out,
    output logic                fsk_out_n,
    output logic                busy,
    output logic                tx_done
);

    logic                state;
    logic                hold_valid;
    logic [SYM_BITS-1:0] hold_sym;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BAUD_W-1:0]   baud_m1;
    logic [DIV_W-1:0]    half;
    logic                sym_end;
    logic                load_now;
    logic                accept;
    logic                phase;

    assign sym_end   = (state == ST_RUN) && (baud_cnt == '0);
    assign load_now  = en && hold_valid && ((state == ST_IDLE) || sym_end);
    // Ready while draining lets a new symbol enter the cycle the hold empties.
    assign sym_ready = !hold_valid || load_now;
    assign accept    = sym_valid && sym_ready;

    assign half    = DIV_W'(sat_half(32'(cfg_base), 32'(cfg_step), 32'(hold_sym), DIV_W));
    assign baud_m1 = (cfg_baud == '0) ? '0 : cfg_baud - BAUD_W'(1);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= ST_IDLE;
            hold_valid <= 1'b0;
            hold_sym   <= '0;
            baud_cnt   <= '0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (accept) begin
                hold_valid <= 1'b1;
                hold_sym   <= sym_data;
            end else if (load_now) begin
                hold_valid <= 1'b0;
            end

            if (load_now) begin
                state    <= ST_RUN;
                baud_cnt <= baud_m1;
            end else if (sym_end) begin
                // A symbol still parked in hold (en low) is not the last one.
                state   <= ST_IDLE;
                tx_done <= !hold_valid;
            end else if (state == ST_RUN) begin
                baud_cnt <= baud_cnt - BAUD_W'(1);
            end
        end
    end

    mfsk_tone_gen #(.DIV_W(DIV_W)) u_tone (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .load  (load_now),
        .run   (busy),
        .half  (half),
        .phase (phase)
    );

    assign busy      = (state == ST_RUN);
    assign fsk_out   = busy & phase;
    assign fsk_out_n = busy & ~phase;

endmodule

// File: tb/tb_mfsk_modulator.sv
// Self-checking bench for mfsk_modulator: directed scenarios plus random
// traffic, all compared cycle-by-cycle against a symbol-level reference model.
module tb_mfsk_modulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [15:0] cfg_step = '0;
    logic [15:0] cfg_baud = '0;
    logic [1:0]  sym_data = '0;
    logic        sym_valid = 1'b0;
    logic        sym_ready, fsk_out, fsk_out_n, busy, tx_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mfsk_modulator dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .en        (en),
        .cfg_base  (cfg_base),
        .cfg_step  (cfg_step),
        .cfg_baud  (cfg_baud),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .fsk_out   (fsk_out),
        .fsk_out_n (fsk_out_n),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    wire [4:0] dut_vec = {fsk_out, fsk_out_n, busy, tx_done, sym_ready};

    // Reference model: pending symbol, active symbol with its cycle index k,
    // and a free-running level/remaining-cycles pair for phase continuity.
    bit m_hold = 0;
    int m_hsym = 0;
    bit m_act = 0;
    int m_k = 0;
    int m_half = 1;
    int m_baud = 1;
    bit m_lvl = 1;
    int m_rem = 1;
    bit m_txd = 0;

    function automatic int f_half(int s);
        longint h;
        h = longint'(cfg_base) + longint'(s) * longint'(cfg_step);
        if (h > 65535) h = 65535;
        if (h == 0) h = 1;
        return int'(h);
    endfunction

    function automatic bit m_load();
        return en && m_hold && (!m_act || m_k == m_baud - 1);
    endfunction

    function automatic logic [4:0] exp_vec();
        bit lvl;
`ifdef MFSK_PHASE_CONT_EN
        lvl = m_lvl;
`else
        lvl = ((m_k / m_half) % 2) == 0;
`endif
        return {m_act & lvl, m_act & ~lvl, m_act, m_txd, !m_hold || m_load()};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit ld, fin, acc;
        int nh;
        if (!rst_n) begin
            m_hold = 0; m_act = 0; m_k = 0; m_half = 1; m_baud = 1;
            m_lvl = 1; m_rem = 1; m_txd = 0;
        end else begin
            ld  = m_load();
            fin = m_act && (m_k == m_baud - 1);
            acc = sym_valid && (!m_hold || ld);
            m_txd = fin && !ld && !m_hold;
            if (ld) begin
                nh = f_half(m_hsym);
                if (m_act) begin
                    m_rem--;
                    if (m_rem == 0) begin m_lvl = !m_lvl; m_rem = nh; end
                end else begin
                    m_lvl = 1; m_rem = nh;
                end
                m_act = 1; m_k = 0; m_half = nh;
                m_baud = (cfg_baud == 16'd0) ? 1 : int'(cfg_baud);
            end else if (fin) begin
                m_act = 0;
            end else if (m_act) begin
                m_k++;
                m_rem--;
                if (m_rem == 0) begin m_lvl = !m_lvl; m_rem = m_half; end
            end
            if (acc) begin m_hold = 1; m_hsym = int'(sym_data); end
            else if (ld) m_hold = 0;
        end
    end

    task automatic test_reset();
        rst_n = 0; en = 0; sym_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (dut_vec !== 5'b00001) begin
            bad++; $display("FAIL reset_state got=%b exp=%b", dut_vec, 5'b00001);
        end
        #1 rst_n = 1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (dut_vec !== 5'b00001) begin
            bad++; $display("FAIL reset_release got=%b exp=%b", dut_vec, 5'b00001);
        end
    endtask

    task automatic test_basic();
        logic [15:0] wave = '0;
        int ndone = 0;
        cfg_base = 4; cfg_step = 2; cfg_baud = 16; en = 1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            sym_valid = (c == 0); sym_data = 2'd0;
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL basic c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
            if (c >= 2 && c < 18) wave[17-c] = fsk_out;
            if (tx_done) ndone++;
        end
        total++;
        if (wave !== 16'b1111000011110000) begin
            bad++; $display("FAIL basic_wave got=%b exp=%b", wave, 16'b1111000011110000);
        end
        total++;
        if (ndone != 1) begin
            bad++; $display("FAIL basic_tx_done got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_all_tones();
        int idx = 0, nbusy = 0, ndone = 0;
        cfg_base = 4; cfg_step = 2; cfg_baud = 16; en = 1;
        for (int c = 0; c < 90; c++) begin
            @(posedge clk); #1;
            sym_valid = (idx < 4); sym_data = 2'(idx);
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL tones c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
            if (busy) nbusy++;
            if (tx_done) ndone++;
            if (sym_valid && sym_ready) idx++;
        end
        total++;
        if (nbusy != 64) begin
            bad++; $display("FAIL tones_busy got=%0d exp=64", nbusy);
        end
        total++;
        if (ndone != 1) begin
            bad++; $display("FAIL tones_tx_done got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_saturation();
        int ones = 0, nbusy = 0, sent = 0;
        logic [7:0] wave = '0;
        en = 1;
        cfg_base = 16'hFFFE; cfg_step = 3; cfg_baud = 20;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            sym_valid = (c == 0); sym_data = 2'd3;
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL sat c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
            if (fsk_out) ones++;
        end
        total++;
        if (ones != 20) begin
            bad++; $display("FAIL sat_high_cycles got=%0d exp=20", ones);
        end
        cfg_base = 0; cfg_step = 0; cfg_baud = 8;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            sym_valid = (c == 0); sym_data = 2'd2;
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL zero_half c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
            if (c >= 2 && c < 10) wave[9-c] = fsk_out;
        end
        total++;
        if (wave !== 8'b10101010) begin
            bad++; $display("FAIL zero_half_wave got=%b exp=%b", wave, 8'b10101010);
        end
        cfg_base = 4; cfg_step = 0; cfg_baud = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            sym_valid = (sent < 3); sym_data = 2'(sent);
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL zero_baud c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
            if (busy) nbusy++;
            if (sym_valid && sym_ready) sent++;
        end
        total++;
        if (nbusy != 3) begin
            bad++; $display("FAIL zero_baud_busy got=%0d exp=3", nbusy);
        end
    endtask

    task automatic test_backpressure_en();
        int nrdy_lo = 0, ndone_off = 0, nbusy_off = 0, nbusy_on = 0, ndone_on = 0;
        cfg_base = 2; cfg_step = 1; cfg_baud = 10; en = 1;
        for (int c = 0; c < 46; c++) begin
            @(posedge clk); #1;
            sym_valid = (c <= 6);
            sym_data  = (c == 0) ? 2'd1 : (c == 1) ? 2'd2 : 2'd3;
            en = !(c >= 7 && c < 20);
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL bp_en c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
            if (c >= 2 && c <= 6 && !sym_ready) nrdy_lo++;
            if (c >= 7 && c < 20 && tx_done) ndone_off++;
            if (c >= 12 && c < 20 && busy) nbusy_off++;
            if (c >= 20 && busy) nbusy_on++;
            if (c >= 20 && tx_done) ndone_on++;
        end
        total++;
        if (nrdy_lo != 5) begin
            bad++; $display("FAIL bp_ready_low got=%0d exp=5", nrdy_lo);
        end
        total++;
        if (ndone_off != 0 || nbusy_off != 0) begin
            bad++; $display("FAIL en_off_idle got done=%0d busy=%0d exp 0 0", ndone_off, nbusy_off);
        end
        total++;
        if (nbusy_on != 10 || ndone_on != 1) begin
            bad++; $display("FAIL en_resume got busy=%0d done=%0d exp 10 1", nbusy_on, ndone_on);
        end
    endtask

    task automatic test_reset_mid();
        int nbusy = 0;
        cfg_base = 3; cfg_step = 1; cfg_baud = 12; en = 1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            sym_valid = (c < 2); sym_data = (c == 0) ? 2'd0 : 2'd2;
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL rst_pre c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (dut_vec !== 5'b00001) begin
            bad++; $display("FAIL reset_async got=%b exp=%b", dut_vec, 5'b00001);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            sym_valid = 0;
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL rst_post c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
            if (busy) nbusy++;
        end
        total++;
        if (nbusy != 0) begin
            bad++; $display("FAIL reset_discard got=%0d exp=0", nbusy);
        end
    endtask

    task automatic test_phase();
        logic [11:0] wave = '0;
        logic [11:0] want;
`ifdef MFSK_PHASE_CONT_EN
        want = 12'b111100_001111;
`else
        want = 12'b111100_111111;
`endif
        cfg_base = 4; cfg_step = 4; cfg_baud = 6; en = 1;
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            sym_valid = (c < 2); sym_data = (c == 0) ? 2'd0 : 2'd1;
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL phase c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
            if (c >= 2 && c < 14) wave[13-c] = fsk_out;
        end
        total++;
        if (wave !== want) begin
            bad++; $display("FAIL phase_wave got=%b exp=%b", wave, want);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            en = ($urandom_range(0, 9) != 0);
            sym_valid = 1'($urandom_range(0, 1));
            sym_data = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                cfg_base = ($urandom_range(0, 7) == 0) ? 16'hFFFD : 16'($urandom_range(0, 6));
                cfg_step = 16'($urandom_range(0, 3));
                cfg_baud = 16'($urandom_range(0, 9));
            end
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_tones();
        test_saturation();
        test_backpressure_en();
        test_reset_mid();
        test_phase();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
